custom_pack_valid_ready: RTL and testbench
==========================================

// Module: custom_pack_valid_ready
// PURPOSE
// - Serial-to-parallel packer: accepts one WIDTH-bit element per valid/ready handshake and emits a DEPTH-element frame.
// - Frames leave as one packed vector on a valid/ready downstream port.
// - Inverse of the frame serializer. Sits in front of the FFT core, gathering sample streams into FFT-sized frames.
// PARAMETERS
// - WIDTH  8  element width, bits
// - DEPTH  4  elements per frame; must be >= 2 (elaboration-time $error otherwise); non-power-of-2 allowed
// PORTS
// - clk         in   1              clock, all state on posedge
// - arstn       in   1              async reset, active-low
// - up_valid    in   1              upstream element valid
// - up_ready    out  1              upstream ready
// - up_data     in   WIDTH          upstream element
// - down_valid  out  1              frame valid
// - down_ready  in   1              downstream ready
// - down_data   out  [DEPTH-1:0][WIDTH-1:0]  packed frame; element k at index k
// - fill_count  out  $clog2(DEPTH+1)  elements held in the fill buffer (0..DEPTH)
// BEHAVIOUR
// - Interface: one clock, clk; reset arstn is asynchronous, active-low.
// - Reset values: up_ready=1, down_valid=0, fill_count=0, write index=0.
//   - Data registers are not reset.
//   - down_data is don't-care while down_valid=0.
// - Handshakes:
//   - Upstream transfer: up_valid & up_ready.
//   - Downstream transfer: down_valid & down_ready.
//   - up_ready and down_valid are registered; no combinational path from down_ready to up_ready.
// - Element placement: the element accepted at write index k is stored to frame slot k.
//   - Index increments per accept; wraps DEPTH-1 -> 0.
//   - First accepted element of a frame lands at down_data[0].
// - Frame state machine, states FILL and HOLD:
//   - FILL: accept elements.
//   - FILL -> HOLD on the accept at index DEPTH-1. down_valid=1 on the following cycle; latency 1 clk from last accept.
//   - HOLD: up_ready=0. down_data stable until popped.
//   - HOLD -> FILL on pop. up_ready=1 and fill_count=0 on the next cycle.
//   - Throughput: DEPTH+1 cycles per frame minimum.
// - Frame rules:
//   - down_valid, once asserted, stays high with stable data until popped (no retraction).
//   - up_valid with up_ready=0: no effect, element is not consumed.
//   - Partial frames are never emitted.
//   - fill_count counts accepted elements of the in-progress frame; it reads DEPTH while HOLD.
// - Reset mid-operation: partial or held frame discarded; all outputs return to reset values asynchronously.
// CONFIGURATION
// - Macro: CUSTOM_PACK_DOUBLE_BUF_EN
// - Undefined: single frame register, behaviour exactly as BEHAVIOUR above.
// - Defined: separate fill buffer and output frame register.
//   - On the last accept: if the output register is empty or popped in the same cycle, the frame moves to the output next cycle.
//     Fill restarts at index 0 and up_ready stays 1, giving DEPTH cycles per frame sustained.
//   - Otherwise the fill buffer holds (fill_count=DEPTH, up_ready=0) until the output register is popped.
//     Transfer happens on that pop edge; up_ready=1 the next cycle.
//   - fill_count reports the fill buffer only.
// STRUCTURE
// - Package custom_fifo_pkg:
//   - state enum pack_state_t {FILL, HOLD}
//   - function ptr_w(DEPTH) = $clog2(DEPTH)
//   - function cnt_w(DEPTH) = $clog2(DEPTH+1)
// - Sub-module custom_wrap_counter:
//   - Parameterised modulo-DEPTH index with inc input.
//   - Outputs: wrap pulse (inc & index==DEPTH-1) and index.
//   - Reused for the write index.
// - Top: counter, frame register(s), state flop(s), handshake logic.
// TESTING
// 1. Reset then hold-off:
//    - Stimulus: arstn low 3 clk, then high with up_valid=0.
//    - Required: up_ready=1, down_valid=0, fill_count=0.
// 2. Basic pack (WIDTH=8, DEPTH=4):
//    - Stimulus: push 0x11,0x22,0x33,0x44 back-to-back, down_ready=1.
//    - Required: down_valid 1 clk after 0x44; down_data[0..3]=11,22,33,44; popped in 1 clk.
// 3. Backpressure:
//    - Stimulus: down_ready=0 for 10 clk after frame complete.
//    - Required: down_valid and down_data stable; up_ready=0 (macro off), or a second frame fills then up_ready=0 (macro on).
// 4. Bubbles:
//    - Stimulus: up_valid toggled 1,0,1,0...
//    - Required: only accepted elements are stored, in order; fill_count steps 0..4.
// 5. Reset mid-frame:
//    - Stimulus: push 2 elements, pulse arstn low.
//    - Required: fill_count=0; next 4 pushes form a complete frame at slots 0..3.
// 6. Throughput (macro on):
//    - Stimulus: continuous up_valid, down_ready=1, 8 frames.
//    - Required: one frame every 4 clk; up_ready never drops.

Source files
------------

// File: rtl/custom_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | custom_fifo_pkg: shared state type and width helpers for packer    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package custom_fifo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/custom_wrap_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | custom_wrap_counter: modulo-DEPTH index with wrap pulse            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module custom_wrap_counter
  import custom_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     i_inc,
  output logic [ptr_w(DEPTH)-1:0]  o_index,
  output logic                     o_wrap
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_index;
  logic          w_at_last;

  assign w_at_last = (r_index == c_LAST);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_index <= '0;
    end else if (i_inc) begin
      r_index <= w_at_last ? '0 : r_index + PW'(1);
    end
  end

  assign o_index = r_index;
  assign o_wrap  = i_inc & w_at_last;

endmodule
`default_nettype wire

// File: rtl/custom_pack_valid_ready.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | custom_pack_valid_ready: packs DEPTH WIDTH-bit elements per frame. |
// | Optional CUSTOM_PACK_DOUBLE_BUF_EN: separate fill and output regs. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module custom_pack_valid_ready
  import custom_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic                          up_valid,
  output logic                          up_ready,
  input  logic [WIDTH-1:0]              up_data,
  output logic                          down_valid,
  input  logic                          down_ready,
  output logic [DEPTH-1:0][WIDTH-1:0]   down_data,
  output logic [cnt_w(DEPTH)-1:0]       fill_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] c_FULL_CNT = CW'(DEPTH);

  generate
    if (DEPTH < 2) begin : g_depth_chk
      $error("custom_pack_valid_ready: DEPTH must be >= 2");
    end
  endgenerate

  pack_state_t   r_state;
  logic          r_up_ready;
  logic          r_down_valid;
  logic [CW-1:0] r_fill_count;

  logic          w_accept;
  logic          w_pop;
  logic          w_wrap;
  logic [PW-1:0] w_idx;

  assign w_accept = up_valid & r_up_ready;
  assign w_pop    = r_down_valid & down_ready;

  custom_wrap_counter #(
    .DEPTH (DEPTH)
  ) u_wr_idx (
    .clk     (clk),
    .arstn   (arstn),
    .i_inc   (w_accept),
    .o_index (w_idx),
    .o_wrap  (w_wrap)
  );

`ifdef CUSTOM_PACK_DOUBLE_BUF_EN

  logic [DEPTH-1:0][WIDTH-1:0] r_fill;
  logic [DEPTH-1:0][WIDTH-1:0] r_out;
  logic [DEPTH-1:0][WIDTH-1:0] w_fill_merged;
  logic                        w_out_free;
  logic                        w_load_direct;
  logic                        w_load_held;

  assign w_out_free    = ~r_down_valid | down_ready;
  assign w_load_direct = w_accept & w_wrap & w_out_free;
  assign w_load_held   = (r_state == HOLD) & w_pop;

  // Completed frame including the element arriving this cycle.
  always_comb begin
    w_fill_merged        = r_fill;
    w_fill_merged[w_idx] = up_data;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state      <= FILL;
      r_up_ready   <= 1'b1;
      r_down_valid <= 1'b0;
      r_fill_count <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_pop) begin
            r_down_valid <= 1'b0;
          end
          if (w_accept) begin
            if (w_wrap) begin
              if (w_out_free) begin
                r_down_valid <= 1'b1;
                r_fill_count <= '0;
              end else begin
                r_state      <= HOLD;
                r_up_ready   <= 1'b0;
                r_fill_count <= c_FULL_CNT;
              end
            end else begin
              r_fill_count <= r_fill_count + CW'(1);
            end
          end
        end
        HOLD: begin
          // Held fill buffer replaces the popped frame; down_valid stays high.
          if (w_pop) begin
            r_state      <= FILL;
            r_up_ready   <= 1'b1;
            r_fill_count <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fill[w_idx] <= up_data;
    end
    if (w_load_direct) begin
      r_out <= w_fill_merged;
    end else if (w_load_held) begin
      r_out <= r_fill;
    end
  end

  assign down_data = r_out;

`else

  logic [DEPTH-1:0][WIDTH-1:0] r_frame;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state      <= FILL;
      r_up_ready   <= 1'b1;
      r_down_valid <= 1'b0;
      r_fill_count <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (w_wrap) begin
              r_state      <= HOLD;
              r_up_ready   <= 1'b0;
              r_down_valid <= 1'b1;
              r_fill_count <= c_FULL_CNT;
            end else begin
              r_fill_count <= r_fill_count + CW'(1);
            end
          end
        end
        HOLD: begin
          if (w_pop) begin
            r_state      <= FILL;
            r_up_ready   <= 1'b1;
            r_down_valid <= 1'b0;
            r_fill_count <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_frame[w_idx] <= up_data;
    end
  end

  assign down_data = r_frame;

`endif

  assign up_ready   = r_up_ready;
  assign down_valid = r_down_valid;
  assign fill_count = r_fill_count;

endmodule
`default_nettype wire

// File: tb/tb_custom_pack_valid_ready.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_custom_pack_valid_ready: directed self-checking bench, W=8 D=4  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_custom_pack_valid_ready;

`ifdef CUSTOM_PACK_DOUBLE_BUF_EN
  localparam bit c_DB = 1'b1;
`else
  localparam bit c_DB = 1'b0;
`endif

  logic             clk;
  logic             arstn;
  logic             up_valid;
  logic             up_ready;
  logic [7:0]       up_data;
  logic             down_valid;
  logic             down_ready;
  logic [3:0][7:0]  down_data;
  logic [2:0]       fill_count;

  int checks;
  int failures;

  custom_pack_valid_ready #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .arstn      (arstn),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .fill_count (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sampling and driving happen 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    up_valid = 1'b1;
    up_data  = d;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    arstn      = 1'b0;
    up_valid   = 1'b0;
    up_data    = 8'h00;
    down_ready = 1'b0;

    // 1. reset then idle
    repeat (3) tick();
    chk("rst_up_ready_in_reset", 64'(up_ready), 64'd1);
    arstn = 1'b1;
    tick();
    chk("rst_up_ready", 64'(up_ready), 64'd1);
    chk("rst_down_valid", 64'(down_valid), 64'd0);
    chk("rst_fill_count", 64'(fill_count), 64'd0);

    // 2. basic pack
    down_ready = 1'b1;
    push(8'h11);
    chk("basic_fill1", 64'(fill_count), 64'd1);
    push(8'h22);
    push(8'h33);
    chk("basic_fill3", 64'(fill_count), 64'd3);
    chk("basic_no_early_valid", 64'(down_valid), 64'd0);
    push(8'h44);
    up_valid = 1'b0;
    chk("basic_valid", 64'(down_valid), 64'd1);
    chk("basic_data", 64'(down_data), 64'h44332211);
    chk("basic_fill_after_last", 64'(fill_count), c_DB ? 64'd0 : 64'd4);
    chk("basic_up_ready_after_last", 64'(up_ready), c_DB ? 64'd1 : 64'd0);
    tick();
    chk("basic_popped", 64'(down_valid), 64'd0);
    chk("basic_up_ready_back", 64'(up_ready), 64'd1);
    chk("basic_fill_zero", 64'(fill_count), 64'd0);

    // 3. backpressure
    down_ready = 1'b0;
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    push(8'hA4);
    for (int i = 0; i < 10; i++) begin
      up_valid = 1'b1;
      up_data  = (i < 4) ? 8'(8'hB1 + i) : 8'hEE;
      chk("bp_valid_stable", 64'(down_valid), 64'd1);
      chk("bp_data_stable", 64'(down_data), 64'hA4A3A2A1);
      tick();
    end
    up_valid = 1'b0;
    chk("bp_valid_end", 64'(down_valid), 64'd1);
    chk("bp_data_end", 64'(down_data), 64'hA4A3A2A1);
    chk("bp_up_ready_low", 64'(up_ready), 64'd0);
    chk("bp_fill_full", 64'(fill_count), 64'd4);
    down_ready = 1'b1;
    tick();
    chk("bp_pop_valid", 64'(down_valid), c_DB ? 64'd1 : 64'd0);
    chk("bp_pop_up_ready", 64'(up_ready), 64'd1);
    chk("bp_pop_fill", 64'(fill_count), 64'd0);
    if (c_DB) chk("bp_second_frame", 64'(down_data), 64'hB4B3B2B1);
    tick();
    chk("bp_drained", 64'(down_valid), 64'd0);
    down_ready = 1'b0;

    // 4. bubbles: only even steps offer valid data
    for (int i = 0; i < 8; i++) begin
      up_valid = (i % 2 == 0);
      up_data  = (i % 2 == 0) ? 8'(8'h50 + i) : 8'hFF;
      tick();
      if (c_DB && i >= 6) chk("bub_fill", 64'(fill_count), 64'd0);
      else                chk("bub_fill", 64'(fill_count), 64'(i / 2 + 1));
    end
    up_valid = 1'b0;
    chk("bub_valid", 64'(down_valid), 64'd1);
    chk("bub_data", 64'(down_data), 64'h56545250);
    down_ready = 1'b1;
    tick();
    chk("bub_popped", 64'(down_valid), 64'd0);
    down_ready = 1'b0;

    // 5. asynchronous reset mid-frame
    push(8'h01);
    push(8'h02);
    up_valid = 1'b0;
    chk("mid_fill_before", 64'(fill_count), 64'd2);
    arstn = 1'b0;
    #2;
    chk("mid_fill_async", 64'(fill_count), 64'd0);
    chk("mid_up_ready_async", 64'(up_ready), 64'd1);
    chk("mid_valid_async", 64'(down_valid), 64'd0);
    arstn = 1'b1;
    tick();
    push(8'hC0);
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    up_valid = 1'b0;
    chk("mid_valid", 64'(down_valid), 64'd1);
    chk("mid_data", 64'(down_data), 64'hC3C2C1C0);
    down_ready = 1'b1;
    tick();
    chk("mid_popped", 64'(down_valid), 64'd0);

`ifdef CUSTOM_PACK_DOUBLE_BUF_EN
    // 6. sustained throughput: one frame every 4 clocks
    for (int j = 0; j < 32; j++) begin
      chk("tp_up_ready", 64'(up_ready), 64'd1);
      push(8'(((j / 4) << 4) + (j % 4)));
      chk("tp_valid", 64'(down_valid), (j % 4 == 3) ? 64'd1 : 64'd0);
      if (j % 4 == 3) begin
        chk("tp_data", 64'(down_data),
            64'({8'(((j / 4) << 4) + 3), 8'(((j / 4) << 4) + 2),
                 8'(((j / 4) << 4) + 1), 8'((j / 4) << 4)}));
      end
    end
    up_valid = 1'b0;
    tick();
    chk("tp_drained", 64'(down_valid), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
